uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: configurable data bits, parity and stop bits.
//  16x oversampled, majority-vote bit recovery, and a show-ahead RX FIFO.

---
 rtl/uart_rx_fifo_if.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receive path and the CPU-facing register block:
// the pop / clear-errors strobes going in, and head data, occupancy and
// sticky error flags coming back.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) ();

  logic                          rx_pop;
  logic                          cmd_clear_errors;
  logic [DATA_BITS-1:0]          rx_data_out;
  logic                          rx_data_valid;
  logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count;
  logic                          rx_frame_error;
  logic                          rx_parity_error;
  logic                          rx_overrun_error;

  // Receiver side: consumes strobes, presents FIFO head and status
  modport slave (
    input  rx_pop,
    input  cmd_clear_errors,
    output rx_data_out,
    output rx_data_valid,
    output rx_fifo_count,
    output rx_frame_error,
    output rx_parity_error,
    output rx_overrun_error
  );

  // CPU side: issues strobes, reads data and status
  modport master (
    output rx_pop,
    output cmd_clear_errors,
    input  rx_data_out,
    input  rx_data_valid,
    input  rx_fifo_count,
    input  rx_frame_error,
    input  rx_parity_error,
    input  rx_overrun_error
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority vote per bit,
// optional parity, 1 or 2 checked stop bits and a show-ahead RX FIFO.
// Frame, parity and overrun errors are sticky until cmd_clear_errors.
module uart_rx_fifo #(
  parameter int CLOCK_SPEED = 2_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_serial_in,
  uart_rx_fifo_if.slave  rx_if
);

  localparam int TICK_RAW = (CLOCK_SPEED + (BAUD_RATE * 8)) / (BAUD_RATE * 16);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_CLKS = TICK_DIV * 16;
  localparam int IDLE_W   = $clog2(BIT_CLKS + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int BITS_W   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           tick_idx;
  logic                 tick;
  logic                 mid_tick;
  logic                 end_tick;
  logic [1:0]           samples;
  logic                 maj;
  logic                 exp_par;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BITS_W-1:0]    bit_cnt;
  logic                 stop_cnt;
  logic                 parity_pending;
  logic [IDLE_W-1:0]    high_cnt;
  logic                 push_req;
  logic [DATA_BITS-1:0] push_data;
  logic                 frame_set;
  logic                 parity_set;
  logic                 overrun_set;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 fifo_full;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  assign rx_sync = sync[1];

  // Two-flop synchroniser for the asynchronous line, idling high, plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx_serial_in};
      rx_prev <= rx_sync;
    end
  end

  assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign mid_tick = tick && (tick_idx == 4'd9);
  assign end_tick = tick && (tick_idx == 4'd15);

  // Oversampling tick generator, held at zero while idle so each frame starts aligned to its start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_idx <= '0;
    end else if (state == S_IDLE || state == S_WAIT_IDLE) begin
      div_cnt  <= '0;
      tick_idx <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_idx <= tick_idx + 4'd1;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Capture the first two mid-bit samples; the third is taken live at tick 9
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samples <= 2'b11;
    end else if (tick && (tick_idx == 4'd7 || tick_idx == 4'd8)) begin
      samples <= {samples[0], rx_sync};
    end
  end

  assign maj     = (samples[1] & samples[0]) | (samples[1] & rx_sync) | (samples[0] & rx_sync);
  assign exp_par = (^shift_reg) ^ (PARITY == 2);

  // Frame sequencer: start validation, data shift, parity and stop checks, push requests and error strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      parity_pending <= 1'b0;
      high_cnt       <= '0;
      push_req       <= 1'b0;
      push_data      <= '0;
      frame_set      <= 1'b0;
      parity_set     <= 1'b0;
    end else begin
      push_req   <= 1'b0;
      frame_set  <= 1'b0;
      parity_set <= 1'b0;
      case (state)
        S_IDLE: begin
          bit_cnt        <= '0;
          stop_cnt       <= 1'b0;
          parity_pending <= 1'b0;
          if (rx_prev && !rx_sync) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (mid_tick && maj) begin
            state <= S_IDLE;
          end else if (end_tick) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (mid_tick) begin
            shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
          end
          if (end_tick) begin
            if (bit_cnt == BITS_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BITS_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (mid_tick) begin
            parity_pending <= (maj != exp_par);
          end
          if (end_tick) begin
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (mid_tick) begin
            if (!maj) begin
              frame_set <= 1'b1;
              high_cnt  <= '0;
              state     <= S_WAIT_IDLE;
            end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
              if (parity_pending) begin
                parity_set <= 1'b1;
              end else begin
                push_req  <= 1'b1;
                push_data <= shift_reg;
              end
              state <= S_IDLE;
            end
          end else if (end_tick) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (!rx_sync) begin
            high_cnt <= '0;
          end else if (high_cnt == IDLE_W'(BIT_CLKS - 1)) begin
            state <= S_IDLE;
          end else begin
            high_cnt <= high_cnt + IDLE_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign pop_ok      = rx_if.rx_pop && (count != '0);
  assign push_ok     = push_req && (!fifo_full || pop_ok);
  assign overrun_set = push_req && fifo_full && !pop_ok;

  // RX FIFO storage, wrapping pointers and separate occupancy counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_set   | (frame_err   & ~rx_if.cmd_clear_errors);
      parity_err  <= parity_set  | (parity_err  & ~rx_if.cmd_clear_errors);
      overrun_err <= overrun_set | (overrun_err & ~rx_if.cmd_clear_errors);
    end
  end

  assign rx_if.rx_data_valid    = (count != '0);
  assign rx_if.rx_data_out      = (count != '0) ? mem[rd_ptr] : '0;
  assign rx_if.rx_fifo_count    = count;
  assign rx_if.rx_frame_error   = frame_err;
  assign rx_if.rx_parity_error  = parity_err;
  assign rx_if.rx_overrun_error = overrun_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance are driven with
// directed frames; received bytes are checked by per-instance monitors that pop
// expected values from queues whenever a byte is dequeued.
module tb_uart_rx_fifo;

  localparam int CLK_HZ   = 2_000_000;
  localparam int BAUD     = 9600;
  localparam int BIT_CLKS = 208;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic line_a = 1'b1;
  logic line_b = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic [7:0] want_a;
  logic [7:0] want_b;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_b ();

  uart_rx_fifo #(
    .CLOCK_SPEED(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .rx_serial_in(line_a), .rx_if(if_a.slave)
  );

  uart_rx_fifo #(
    .CLOCK_SPEED(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .rx_serial_in(line_b), .rx_if(if_b.slave)
  );

  // 100 MHz-style free-running clock (period is arbitrary; timing is in cycles)
  always #5 clk = ~clk;

  // Monitor for the 8N1 instance: every accepted pop must match the oldest expected byte
  always @(negedge clk) begin
    if (!reset && if_a.rx_pop && if_a.rx_data_valid) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_a_unexpected got %02h expected none", if_a.rx_data_out);
      end else begin
        want_a = exp_a.pop_front();
        if (if_a.rx_data_out !== want_a) begin
          errors++;
          $display("[TB] FAIL pop_a_data got %02h expected %02h", if_a.rx_data_out, want_a);
        end
      end
    end
  end

  // Monitor for the 8E1 instance
  always @(negedge clk) begin
    if (!reset && if_b.rx_pop && if_b.rx_data_valid) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_b_unexpected got %02h expected none", if_b.rx_data_out);
      end else begin
        want_b = exp_b.pop_front();
        if (if_b.rx_data_out !== want_b) begin
          errors++;
          $display("[TB] FAIL pop_b_data got %02h expected %02h", if_b.rx_data_out, want_b);
        end
      end
    end
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) line_b = v;
    else     line_a = v;
    idle(BIT_CLKS);
  endtask

  // One serial frame: start, 8 data bits LSB first, optional parity, one stop bit
  task automatic apply_stimulus(input bit sel, input logic [7:0] data, input bit use_par,
                                input logic par_val, input logic stop_val);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (use_par) drive_bit(sel, par_val);
    drive_bit(sel, stop_val);
    if (sel) line_b = 1'b1;
    else     line_a = 1'b1;
  endtask

  task automatic wait_valid(input bit sel, input int budget, input string name);
    int n = 0;
    while (!(sel ? if_b.rx_data_valid : if_a.rx_data_valid) && n < budget) begin
      idle(1);
      n++;
    end
    check_output(name, 32'(sel ? if_b.rx_data_valid : if_a.rx_data_valid), 32'd1);
  endtask

  task automatic pop(input bit sel);
    if (sel) if_b.rx_pop = 1'b1;
    else     if_a.rx_pop = 1'b1;
    idle(1);
    if_a.rx_pop = 1'b0;
    if_b.rx_pop = 1'b0;
  endtask

  task automatic clear_errors(input bit sel);
    if (sel) if_b.cmd_clear_errors = 1'b1;
    else     if_a.cmd_clear_errors = 1'b1;
    idle(1);
    if_a.cmd_clear_errors = 1'b0;
    if_b.cmd_clear_errors = 1'b0;
  endtask

  function automatic logic [2:0] flags_a();
    return {if_a.rx_frame_error, if_a.rx_parity_error, if_a.rx_overrun_error};
  endfunction

  // Directed sequence
  initial begin
    if_a.rx_pop = 1'b0;
    if_a.cmd_clear_errors = 1'b0;
    if_b.rx_pop = 1'b0;
    if_b.cmd_clear_errors = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check_output("reset_count", 32'(if_a.rx_fifo_count), 32'd0);
    check_output("reset_valid", 32'(if_a.rx_data_valid), 32'd0);
    check_output("reset_data", 32'(if_a.rx_data_out), 32'h00);
    check_output("reset_flags", 32'(flags_a()), 32'd0);
    reset = 1'b0;
    idle(20);

    $display("[TB] single byte 0xA5");
    exp_a.push_back(8'hA5);
    apply_stimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, 2 * BIT_CLKS, "t1_valid");
    check_output("t1_data", 32'(if_a.rx_data_out), 32'hA5);
    check_output("t1_count", 32'(if_a.rx_fifo_count), 32'd1);
    check_output("t1_flags", 32'(flags_a()), 32'd0);
    pop(1'b0);
    check_output("t1_valid_after_pop", 32'(if_a.rx_data_valid), 32'd0);
    check_output("t1_count_after_pop", 32'(if_a.rx_fifo_count), 32'd0);

    $display("[TB] frame error then recovery");
    apply_stimulus(1'b0, 8'hDD, 1'b0, 1'b0, 1'b0);
    idle(10);
    check_output("t2_frame_err", 32'(if_a.rx_frame_error), 32'd1);
    check_output("t2_count", 32'(if_a.rx_fifo_count), 32'd0);
    clear_errors(1'b0);
    check_output("t2_frame_cleared", 32'(if_a.rx_frame_error), 32'd0);
    idle(2 * BIT_CLKS);
    exp_a.push_back(8'h3C);
    apply_stimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, 2 * BIT_CLKS, "t2_valid");
    check_output("t2_data", 32'(if_a.rx_data_out), 32'h3C);
    check_output("t2_flags", 32'(flags_a()), 32'd0);
    pop(1'b0);

    $display("[TB] even parity");
    apply_stimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(10);
    check_output("t3_parity_err", 32'(if_b.rx_parity_error), 32'd1);
    check_output("t3_count", 32'(if_b.rx_fifo_count), 32'd0);
    check_output("t3_frame_err", 32'(if_b.rx_frame_error), 32'd0);
    exp_b.push_back(8'h07);
    apply_stimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_valid(1'b1, 2 * BIT_CLKS, "t3_valid");
    check_output("t3_data", 32'(if_b.rx_data_out), 32'h07);
    check_output("t3_count_good", 32'(if_b.rx_fifo_count), 32'd1);
    pop(1'b1);
    check_output("t3_valid_after_pop", 32'(if_b.rx_data_valid), 32'd0);

    $display("[TB] overrun");
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_a.push_back(8'h10 + 8'(k));
      apply_stimulus(1'b0, 8'h10 + 8'(k), 1'b0, 1'b0, 1'b1);
    end
    idle(10);
    check_output("t4_count", 32'(if_a.rx_fifo_count), 32'd4);
    check_output("t4_overrun", 32'(if_a.rx_overrun_error), 32'd1);
    check_output("t4_head", 32'(if_a.rx_data_out), 32'h10);
    for (int k = 0; k < 4; k++) pop(1'b0);
    check_output("t4_valid_drained", 32'(if_a.rx_data_valid), 32'd0);
    check_output("t4_count_drained", 32'(if_a.rx_fifo_count), 32'd0);
    clear_errors(1'b0);
    check_output("t4_overrun_cleared", 32'(if_a.rx_overrun_error), 32'd0);

    $display("[TB] glitch and empty pop");
    line_a = 1'b0;
    idle(3);
    line_a = 1'b1;
    idle(2 * BIT_CLKS);
    pop(1'b0);
    idle(2);
    check_output("t5_count", 32'(if_a.rx_fifo_count), 32'd0);
    check_output("t5_valid", 32'(if_a.rx_data_valid), 32'd0);
    check_output("t5_flags", 32'(flags_a()), 32'd0);

    $display("[TB] reset mid-frame");
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, (i == 1 || i == 3) ? 1'b1 : 1'b0);
    reset  = 1'b1;
    line_a = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(1);
    check_output("t6_count", 32'(if_a.rx_fifo_count), 32'd0);
    check_output("t6_valid", 32'(if_a.rx_data_valid), 32'd0);
    check_output("t6_flags", 32'(flags_a()), 32'd0);
    idle(BIT_CLKS);
    exp_a.push_back(8'h81);
    apply_stimulus(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_valid(1'b0, 2 * BIT_CLKS, "t6_valid_new");
    check_output("t6_data", 32'(if_a.rx_data_out), 32'h81);
    check_output("t6_count_new", 32'(if_a.rx_fifo_count), 32'd1);
    check_output("t6_flags_new", 32'(flags_a()), 32'd0);
    pop(1'b0);
    idle(5);

    check_output("queue_a_drained", 32'(exp_a.size()), 32'd0);
    check_output("queue_b_drained", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
